load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-access (MEM) stage of the 5-stage RV32I pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register.
- Runs loads and stores against a single-port data-memory bus with a req/ack handshake.
- Aligns and sign- or zero-extends load data.
- Stalls the upstream pipeline while a transaction is outstanding.
- Flags misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 16, BUSY cycles without mem_ack before the access is aborted with a bus error.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous reset, active-high.
ex_valid  in  1  EX/MEM slot holds a valid instruction.
ex_mem_read  in  1  instruction is a load.
ex_mem_write  in  1  instruction is a store.
ex_funct3  in  3  access size/sign code (RV32I encoding).
ex_alu_out  in  32  effective address for memory ops; result to forward for non-memory ops.
ex_store_data  in  32  rs2 value for stores.
ex_rd  in  5  destination register.
ex_reg_write  in  1  instruction writes rd.
stall  out  1  high means upstream must hold its EX/MEM contents.
mem_req  out  1  bus request.
mem_we  out  1  write enable.
mem_addr  out  32  word-aligned address; bits [1:0] are always 0.
mem_wdata  out  32  lane-shifted store data.
mem_wstrb  out  4  byte-lane write strobes.
mem_ack  in  1  bus completion; read data is valid in the same cycle.
mem_rdata  in  32  read word.
wb_valid  out  1  one-cycle pulse with the MEM/WB payload.
wb_rd  out  5  destination register.
wb_reg_write  out  1  register write enable.
wb_data  out  32  extended load data, or passed-through ex_alu_out.
exc_valid  out  1  one-cycle pulse, coincident with wb_valid, reporting a fault.
exc_code  out  2  fault code: 01 misaligned, 10 illegal funct3, 11 bus timeout.

Behaviour:
Reset values:
- All outputs are 0 and the FSM is in IDLE.
- Reset overrides everything, including a mem_ack in the same cycle. An in-flight transaction is abandoned and mem_req is low the cycle after reset.

Input acceptance and stall:
- Inputs are accepted when ex_valid && !stall.
- stall = (state == BUSY), driven combinationally.

IDLE state, on accepting an instruction:
- Non-memory op: next cycle drives wb_valid=1 with wb_rd, wb_reg_write and wb_data=ex_alu_out. Latency 1, throughput 1 per cycle.
- Memory op with a fault, checked in this order:
  - illegal funct3: loads allow only 000, 001, 010, 100, 101; stores allow only 000, 001, 010. Code 10.
  - halfword with addr[0]=1, or word with addr[1:0]!=0: code 01.
  - Result: no bus request; next cycle wb_valid=1, wb_reg_write=0, exc_valid=1 with the code.
- Legal memory op:
  - Latch the operation.
  - Move to BUSY next cycle with mem_req=1.
  - Set mem_addr={addr[31:2],2'b00} and mem_we=ex_mem_write.
- ex_mem_read && ex_mem_write both high: treat as illegal, code 10.

Store lane formatting:
- SB: wdata = {4{byte}}, wstrb = 0001 << addr[1:0].
- SH: wdata = {2{half}}, wstrb = 0011 << addr[1:0].
- SW: wdata = store data, wstrb = 1111.
- Loads drive wstrb = 0000.

BUSY state:
- mem_req, mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until mem_ack.
- On mem_ack:
  - mem_req drops next cycle; return to IDLE.
  - Next cycle wb_valid=1.
  - For loads, wb_data is mem_rdata shifted right by addr[1:0]*8, then sign-extended (LB/LH) or zero-extended (LBU/LHU); LW is unmodified. wb_reg_write is the latched value.
  - For stores, wb_reg_write=0.
- Timeout counter:
  - 5-bit counter, cleared on entering BUSY, increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 without ack: abort, drop mem_req next cycle, return to IDLE, and pulse wb_valid with wb_reg_write=0, exc_valid=1, exc_code=11.
  - An ack in that same cycle wins over the timeout.

Other rules:
- mem_ack outside BUSY is ignored.
- wb_valid and exc_valid are single-cycle pulses; the other wb_* outputs hold their last value.
- Minimum memory-op latency is 2 cycles from accept to wb_valid when ack arrives on the first BUSY cycle.
- Writes to rd=0 pass through unchanged; the register file discards them.

Decomposition:
- Shared package / define file: FSM state encodings (IDLE, BUSY), funct3 size constants (LB, LH, LW, LBU, LHU, SB, SH, SW), and exc_code constants.
- One natural sub-module, lsu_load_align: combinational extraction and sign/zero-extension from rdata, addr[1:0] and funct3.

Test Plan:
1. Non-memory op with ex_alu_out=0x0000_1234, rd=5 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x0000_1234, stall stays 0.
2. LB at addr 0x103, mem_rdata=0x80FF_0000, ack on first BUSY cycle:
   - mem_addr=0x100.
   - wb_data=0xFFFF_FF80.
   - The same case as LBU gives 0x0000_0080.
3. SH at addr 0x202 with store data 0x0000_ABCD -> mem_wdata=0xABCD_ABCD, mem_wstrb=1100, mem_we=1; after ack, wb_reg_write=0.
4. LW at addr 0x006 -> no mem_req; next cycle exc_valid=1, exc_code=01, wb_reg_write=0.
5. Ack withheld:
   - LW to 0x40, no ack -> stall high and mem_req held for 16 cycles, then exc_code=11 and IDLE.
   - Repeat with ack on the 16th BUSY cycle -> normal completion.
6. Reset asserted on the 3rd BUSY cycle alongside mem_ack -> next cycle mem_req=0, wb_valid=0, stall=0, and the next instruction is accepted normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - lsu_state_e : FSM encodings (IDLE, BUSY)
//   - F3_*        : RV32I funct3 access-size codes for loads and stores
//   - EXC_*       : fault codes reported on exc_code
//   - f3_legal()  : funct3 legality check for a load or a store
package load_store_unit_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) return f3 inside {F3_SB, F3_SH, F3_SW};
        return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the read
// word and sign- or zero-extends it.
//   rdata   : raw 32-bit word from the bus
//   addr_lo : byte offset within the word
//   funct3  : load size/sign code
//   data    : value to write back to rd
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        data = rdata;
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  data = {24'b0, shifted[7:0]};
            F3_LHU:  data = {16'b0, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM stage of the RV32I pipeline. Runs loads/stores over a req/ack data
// bus, aligns load data, stalls upstream while a bus access is in flight and
// reports misaligned, illegal and timed-out accesses.
//   ex_*  : EX/MEM slot (valid, read/write, funct3, address/result, store
//           data, rd, reg_write)
//   stall : upstream must hold while high
//   mem_* : data bus (req, we, word address, lane data, strobes, ack, rdata)
//   wb_*  : MEM/WB payload, wb_valid is a one-cycle pulse
//   exc_* : fault pulse coincident with wb_valid, plus fault code
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_code
);

    localparam logic [4:0] TO_LAST = 5'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic [4:0]  tcnt_q;
    logic        lat_read, lat_reg_write;
    logic [4:0]  lat_rd;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_lo;

    logic        accept, is_mem, illegal, misalign, timeout;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_wstrb;

    assign stall    = (state_q == BUSY);
    assign accept   = ex_valid && !stall;
    assign is_mem   = ex_mem_read || ex_mem_write;
    // Read+write together is never a real instruction; call it illegal.
    assign illegal  = (ex_mem_read && ex_mem_write) || !f3_legal(ex_mem_write, ex_funct3);
    // Only meaningful once funct3 is known legal; SH shares LH's code.
    assign misalign = ((ex_funct3 == F3_LH || ex_funct3 == F3_LHU) && ex_alu_out[0]) ||
                      (ex_funct3 == F3_LW && ex_alu_out[1:0] != 2'b00);
    // Ack in the last allowed cycle still completes the access.
    assign timeout  = (state_q == BUSY) && !mem_ack && (tcnt_q == TO_LAST);

    always_comb begin
        st_wdata = ex_store_data;
        st_wstrb = 4'b0000;
        if (ex_mem_write) begin
            case (ex_funct3)
                F3_SB: begin
                    st_wdata = {4{ex_store_data[7:0]}};
                    st_wstrb = 4'b0001 << ex_alu_out[1:0];
                end
                F3_SH: begin
                    st_wdata = {2{ex_store_data[15:0]}};
                    st_wstrb = 4'b0011 << ex_alu_out[1:0];
                end
                default: st_wstrb = 4'b1111;
            endcase
        end
    end

    lsu_load_align u_align (
        .rdata   (mem_rdata),
        .addr_lo (lat_lo),
        .funct3  (lat_f3),
        .data    (ld_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && is_mem && !illegal && !misalign) state_d = BUSY;
            BUSY: if (mem_ack || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            wb_data       <= '0;
            exc_valid     <= 1'b0;
            exc_code      <= '0;
            tcnt_q        <= '0;
            lat_read      <= 1'b0;
            lat_reg_write <= 1'b0;
            lat_rd        <= '0;
            lat_f3        <= '0;
            lat_lo        <= '0;
        end else begin
            wb_valid  <= 1'b0;
            exc_valid <= 1'b0;
            if (accept) begin
                if (!is_mem) begin
                    wb_valid     <= 1'b1;
                    wb_rd        <= ex_rd;
                    wb_reg_write <= ex_reg_write;
                    wb_data      <= ex_alu_out;
                end else if (illegal || misalign) begin
                    wb_valid     <= 1'b1;
                    wb_rd        <= ex_rd;
                    wb_reg_write <= 1'b0;
                    exc_valid    <= 1'b1;
                    exc_code     <= illegal ? EXC_ILLEGAL : EXC_MISALIGN;
                end else begin
                    mem_req       <= 1'b1;
                    mem_we        <= ex_mem_write;
                    mem_addr      <= {ex_alu_out[31:2], 2'b00};
                    mem_wdata     <= st_wdata;
                    mem_wstrb     <= st_wstrb;
                    tcnt_q        <= '0;
                    lat_read      <= ex_mem_read;
                    lat_reg_write <= ex_reg_write;
                    lat_rd        <= ex_rd;
                    lat_f3        <= ex_funct3;
                    lat_lo        <= ex_alu_out[1:0];
                end
            end else if (state_q == BUSY) begin
                if (mem_ack) begin
                    mem_req      <= 1'b0;
                    wb_valid     <= 1'b1;
                    wb_rd        <= lat_rd;
                    wb_reg_write <= lat_read && lat_reg_write;
                    if (lat_read) wb_data <= ld_data;
                end else if (timeout) begin
                    mem_req      <= 1'b0;
                    wb_valid     <= 1'b1;
                    wb_rd        <= lat_rd;
                    wb_reg_write <= 1'b0;
                    exc_valid    <= 1'b1;
                    exc_code     <= EXC_TIMEOUT;
                end else begin
                    tcnt_q <= tcnt_q + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. Expected write-back records are
// queued when an instruction is driven and compared when wb_valid pulses.
module tb_load_store_unit;

    localparam int TO = 16;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
        logic        chk_data;
        logic        exc;
        logic [1:0]  code;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_alu_out = '0, ex_store_data = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid, wb_reg_write, exc_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  exc_code;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .exc_valid(exc_valid), .exc_code(exc_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic rw, input logic [31:0] data,
                        input logic chk_data, input logic exc, input logic [1:0] code);
        exp_t x;
        x.rd = rd; x.rw = rw; x.data = data; x.chk_data = chk_data; x.exc = exc; x.code = code;
        sb.push_back(x);
    endtask

    // Write-back monitor, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        if (wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_spurious", 32'(wb_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                if (e.chk_data) chk("wb_data", wb_data, e.data);
                chk("exc_valid", 32'(exc_valid), 32'(e.exc));
                if (e.exc) chk("exc_code", 32'(exc_code), 32'(e.code));
            end
        end else begin
            chk("exc_without_wb", 32'(exc_valid), 32'd0);
        end
    end

    task automatic drive(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd, input logic rw);
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_read = rd_op; ex_mem_write = wr_op; ex_funct3 = f3;
        ex_alu_out = addr; ex_store_data = sdata; ex_rd = rd; ex_reg_write = rw;
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    // Drive a legal memory op, check the bus phase each BUSY cycle and ack on
    // BUSY cycle ack_at (0 = never ack).
    task automatic do_mem(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic rw, input logic [31:0] rdata,
                          input int ack_at, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
        drive(rd_op, wr_op, f3, addr, sdata, rd, rw);
        for (int c = 1; c <= TO; c++) begin
            chk("stall_busy", 32'(stall), 32'd1);
            chk("mem_req", 32'(mem_req), 32'd1);
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_we", 32'(mem_we), 32'(wr_op));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
            if (wr_op) chk("mem_wdata", mem_wdata, exp_wdata);
            if (c == ack_at) begin
                mem_ack = 1'b1;
                mem_rdata = rdata;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            if (c == ack_at) break;
        end
        chk("mem_req_drop", 32'(mem_req), 32'd0);
        chk("stall_idle", 32'(stall), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {27'b0, stall, mem_req, mem_we, wb_valid, exc_valid}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_wb", {24'b0, wb_rd, wb_reg_write, exc_code}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        reset = 1'b0;

        // Non-memory op, then a back-to-back burst (one per cycle).
        push(5'd5, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 2'b00);
        drive(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        chk("stall_nonmem", 32'(stall), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            push(5'(i), 1'b1, 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 2'b00);
            ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
            ex_alu_out = 32'hA000_0000 + 32'(i); ex_rd = 5'(i); ex_reg_write = 1'b1;
            @(negedge clk);
        end
        ex_valid = 1'b0;

        // Loads with alignment / extension.
        push(5'd3, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 2'b00);
        do_mem(1, 0, 3'b000, 32'h103, 0, 5'd3, 1, 32'h80FF_0000, 1, 32'h100, 0, 4'b0000);
        push(5'd4, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 2'b00);
        do_mem(1, 0, 3'b100, 32'h103, 0, 5'd4, 1, 32'h80FF_0000, 1, 32'h100, 0, 4'b0000);
        push(5'd6, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 2'b00);
        do_mem(1, 0, 3'b001, 32'h202, 0, 5'd6, 1, 32'h8001_0000, 2, 32'h200, 0, 4'b0000);
        push(5'd7, 1'b1, 32'h0000_8001, 1'b1, 1'b0, 2'b00);
        do_mem(1, 0, 3'b101, 32'h202, 0, 5'd7, 1, 32'h8001_0000, 1, 32'h200, 0, 4'b0000);
        push(5'd8, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'b00);
        do_mem(1, 0, 3'b010, 32'h40, 0, 5'd8, 1, 32'hDEAD_BEEF, 3, 32'h40, 0, 4'b0000);

        // Stores: lane replication and strobes; never write rd.
        push(5'd9, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        do_mem(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 5'd9, 1, 0, 1, 32'h200, 32'hABCD_ABCD, 4'b1100);
        push(5'd10, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        do_mem(0, 1, 3'b000, 32'h101, 32'h1234_5678, 5'd10, 1, 0, 1, 32'h100, 32'h7878_7878, 4'b0010);
        push(5'd11, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        do_mem(0, 1, 3'b010, 32'h300, 32'hCAFE_F00D, 5'd11, 0, 0, 2, 32'h300, 32'hCAFE_F00D, 4'b1111);

        // Faults: no bus request, single exception pulse.
        push(5'd12, 1'b0, 32'h0, 1'b0, 1'b1, 2'b01);
        drive(1'b1, 1'b0, 3'b010, 32'h006, 32'h0, 5'd12, 1'b1);
        chk("fault_no_req", 32'(mem_req), 32'd0);
        chk("fault_no_stall", 32'(stall), 32'd0);
        push(5'd13, 1'b0, 32'h0, 1'b0, 1'b1, 2'b01);
        drive(1'b1, 1'b0, 3'b001, 32'h001, 32'h0, 5'd13, 1'b1);
        push(5'd14, 1'b0, 32'h0, 1'b0, 1'b1, 2'b10);
        drive(1'b1, 1'b0, 3'b011, 32'h000, 32'h0, 5'd14, 1'b1);
        push(5'd15, 1'b0, 32'h0, 1'b0, 1'b1, 2'b10);
        drive(1'b0, 1'b1, 3'b100, 32'h003, 32'h0, 5'd15, 1'b0);
        push(5'd16, 1'b0, 32'h0, 1'b0, 1'b1, 2'b10);
        drive(1'b1, 1'b1, 3'b010, 32'h000, 32'h0, 5'd16, 1'b1);
        chk("illegal_no_req", 32'(mem_req), 32'd0);

        // Ack withheld: timeout, then ack on the very last cycle.
        push(5'd17, 1'b0, 32'h0, 1'b0, 1'b1, 2'b11);
        do_mem(1, 0, 3'b010, 32'h40, 0, 5'd17, 1, 0, 0, 32'h40, 0, 4'b0000);
        push(5'd18, 1'b1, 32'h1357_9BDF, 1'b1, 1'b0, 2'b00);
        do_mem(1, 0, 3'b010, 32'h40, 0, 5'd18, 1, 32'h1357_9BDF, TO, 32'h40, 0, 4'b0000);

        // Reset with an ack on the 3rd BUSY cycle abandons the access.
        drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd19, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b0;
        chk("rst_busy_req", 32'(mem_req), 32'd0);
        chk("rst_busy_wb", 32'(wb_valid), 32'd0);
        chk("rst_busy_stall", 32'(stall), 32'd0);
        push(5'd0, 1'b1, 32'h0000_0BAD, 1'b1, 1'b0, 2'b00);
        drive(1'b0, 1'b0, 3'b000, 32'h0000_0BAD, 32'h0, 5'd0, 1'b1);
        push(5'd20, 1'b1, 32'h0000_0077, 1'b1, 1'b0, 2'b00);
        do_mem(1, 0, 3'b100, 32'h41, 0, 5'd20, 1, 32'h0000_7700, 1, 32'h40, 0, 4'b0000);

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
